// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared RISC-V core definitions used by the fetch stage and its helpers.
//   XLEN          : address / PC width
//   ILEN          : instruction word width
//   INSTR_BYTES   : byte stride between sequential instructions
//   fetch_state_e : instruction fetch FSM states
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// ----------------------------------------------------------------------------
// fetch_buf
// One-entry holding register for a fetched instruction and its PC.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture instr_d / pc_d and mark the entry valid
//   clear      : invalidate the entry (contents are left untouched)
//   instr_d    : instruction word to capture
//   pc_d       : PC of instr_d
//   valid      : entry holds an instruction for decode
//   instr, pc  : buffered instruction and its PC
// ----------------------------------------------------------------------------
module fetch_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [ILEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc_d,
    output logic            valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_d;
            pc    <= pc_d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage closing the loop around the program counter. It
// fetches the word at pc_current over a req/gnt/rvalid memory handshake,
// buffers it for decode behind a valid/ready handshake, and computes pc_next.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   pc_current        : PC register output
//   pc_next           : PC register input (hold / +4 / redirect target)
//   redirect_valid    : one-cycle branch/jump redirect request
//   redirect_target   : redirect address
//   imem_req          : memory request (REQ state only)
//   imem_addr         : memory request address
//   imem_gnt          : memory accepted the request this cycle
//   imem_rvalid       : memory response valid
//   imem_rdata        : memory response data
//   if_valid          : instruction available to decode
//   if_ready          : decode accepts the instruction
//   if_instr, if_pc   : buffered instruction and its PC
//   fetch_fault       : one-cycle pulse after an ignored misaligned redirect
//
// Build option
//   FETCH_MISALIGN_CHK_EN : when defined, redirects whose target is not
//   word-aligned are dropped and flagged on fetch_fault. When undefined, the
//   low target bits are cleared and the redirect proceeds; fetch_fault is 0.
// ----------------------------------------------------------------------------
module instr_fetch
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_current,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_fault
);

    fetch_state_e    state, state_nxt;
    logic            drop_q, drop_nxt;   // pending response belongs to a squashed fetch
    logic            buf_load, buf_clear;
    logic            redir_take;
    logic [XLEN-1:0] redir_addr;

    // ------------------------------------------------------------------------
    // Redirect qualification
    // ------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHK_EN
    logic redir_misaligned;
    logic fault_q;

    assign redir_misaligned = (redirect_target[1:0] != 2'b00);
    assign redir_take       = redirect_valid && !redir_misaligned;
    assign redir_addr       = redirect_target;

    // Pulses in the cycle after the offending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= redirect_valid && redir_misaligned;
    end

    assign fetch_fault = fault_q;
`else
    assign redir_take  = redirect_valid;
    assign redir_addr  = redirect_target & ~(XLEN'(INSTR_BYTES - 1));
    assign fetch_fault = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State and drop flag registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            drop_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= drop_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, PC selection and memory request
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave a latch behind.
        state_nxt = state;
        drop_nxt  = drop_q;
        pc_next   = pc_current;
        imem_req  = 1'b0;
        imem_addr = '0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;

        unique case (state)
            IDLE: begin
                state_nxt = REQ;
            end

            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_current;
                if (imem_gnt) begin
                    state_nxt = WAIT;
                    // Request already issued for the old PC: squash its reply.
                    if (redir_take) drop_nxt = 1'b1;
                end
            end

            WAIT: begin
                if (redir_take) begin
                    if (imem_rvalid) begin
                        // The outstanding reply arrives now and is discarded,
                        // so nothing is left to drop: refetch at once.
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        drop_nxt  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                    end else begin
                        buf_load  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redir_take) begin
                    buf_clear = 1'b1;
                    state_nxt = REQ;
                end else if (if_valid && if_ready) begin
                    pc_next   = pc_current + XLEN'(INSTR_BYTES);
                    buf_clear = 1'b1;
                    state_nxt = REQ;
                end
            end

            default: state_nxt = IDLE;
        endcase

        // A taken redirect overrides hold and +4 in every state.
        if (redir_take) pc_next = redir_addr;
    end

    // ------------------------------------------------------------------------
    // Decode-side holding register
    // ------------------------------------------------------------------------
    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .clear   (buf_clear),
        .instr_d (imem_rdata),
        .pc_d    (pc_current),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. The bench owns the PC register that
// closes the loop and a simple instruction memory whose word at address A is
// mem_word(A). A program-order scoreboard tracks the PC that the next word
// delivered to decode must come from.
// ----------------------------------------------------------------------------
module tb_instr_fetch;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_current;
    logic [XLEN-1:0] pc_next;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            fetch_fault;

    always #5 clk = ~clk;

    // PC register that the fetch stage steers.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_current <= '0;
        else     pc_current <= pc_next;
    end

    instr_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .pc_current      (pc_current),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fetch_fault     (fetch_fault)
    );

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Redirect rules seen from outside the block.
    function automatic logic redir_eff(input logic v, input logic [31:0] t);
        return MIS ? (v && t[1:0] == 2'b00) : v;
    endfunction

    function automatic logic fault_cause(input logic v, input logic [31:0] t);
        return MIS && v && (t[1:0] != 2'b00);
    endfunction

    // Memory model state.
    logic        m_pend;
    logic [31:0] m_addr;
    int          m_lat;
    int          lat_cfg = 0;

    // Samples of the current cycle.
    logic        s_req, s_valid, s_fault;
    logic [31:0] s_addr, s_pc_next, s_instr, s_pc, s_pc_cur;

    // Scoreboard state.
    logic [31:0] exp_pc;
    logic        fault_pend;
    logic        prev_stall, prev_req_hold;
    logic [31:0] prev_instr, prev_pc, prev_addr;
    int          n_accept;

    task automatic sb_reset();
        exp_pc        = 32'h0;
        fault_pend    = 1'b0;
        prev_stall    = 1'b0;
        prev_req_hold = 1'b0;
        m_pend        = 1'b0;
        m_lat         = 0;
    endtask

    task automatic scoreboard();
        logic        redir;
        logic [31:0] tgt, exp_next;
        redir = redir_eff(redirect_valid, redirect_target);
        tgt   = redirect_target & 32'hFFFF_FFFC;

        exp_next = redir ? tgt : ((s_valid && if_ready) ? s_pc_cur + 32'd4 : s_pc_cur);
        check("pc_next", s_pc_next, exp_next);

        check("fetch_fault", {31'b0, s_fault}, {31'b0, fault_pend});
        fault_pend = fault_cause(redirect_valid, redirect_target);

        check("no_req_while_valid", {31'b0, s_req && s_valid}, 32'h0);
        if (s_req) check("req_addr_is_pc", s_addr, s_pc_cur);

        if (prev_stall) begin
            check("stall_valid", {31'b0, s_valid}, 32'h1);
            check("stall_instr", s_instr, prev_instr);
            check("stall_pc", s_pc, prev_pc);
        end
        if (prev_req_hold) begin
            check("req_held", {31'b0, s_req}, 32'h1);
            check("req_addr_held", s_addr, prev_addr);
        end

        if (s_valid && if_ready) begin
            n_accept++;
            check("deliver_pc", s_pc, exp_pc);
            check("deliver_instr", s_instr, mem_word(s_pc));
            exp_pc = s_pc + 32'd4;
        end
        if (redir) exp_pc = tgt;

        prev_stall    = s_valid && !if_ready && !redir;
        prev_instr    = s_instr;
        prev_pc       = s_pc;
        prev_req_hold = s_req && !imem_gnt && !redir;
        prev_addr     = s_addr;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later.
    task automatic cycle(input logic redir, input logic [31:0] tgt, input logic rdy,
                         input logic gnt, input logic rv_allow);
        @(negedge clk);
        redirect_valid  = redir;
        redirect_target = tgt;
        if_ready        = rdy;
        imem_gnt        = gnt;
        imem_rvalid     = m_pend && (m_lat == 0) && rv_allow;
        imem_rdata      = imem_rvalid ? mem_word(m_addr) : 32'hBAD0_0000 ^ $urandom_range(0, 255);
        #1;
        s_req     = imem_req;
        s_addr    = imem_addr;
        s_pc_next = pc_next;
        s_valid   = if_valid;
        s_instr   = if_instr;
        s_pc      = if_pc;
        s_fault   = fetch_fault;
        s_pc_cur  = pc_current;
        scoreboard();
        if (s_req) check("one_outstanding", {31'b0, m_pend}, 32'h0);
        if (imem_rvalid)            m_pend = 1'b0;
        else if (m_pend && m_lat > 0) m_lat--;
        if (s_req && imem_gnt) begin
            m_pend = 1'b1;
            m_addr = s_addr;
            m_lat  = lat_cfg;
        end
    endtask

    // Reset: check reset outputs, release, check the IDLE cycle.
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        if_ready        = 1'b0;
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = '0;
        #1;
        check("rst_imem_req", {31'b0, imem_req}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_valid", {31'b0, if_valid}, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_fetch_fault", {31'b0, fetch_fault}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sb_reset();
        #1;
        check("idle_no_req", {31'b0, imem_req}, 32'h0);
    endtask

    typedef struct {
        int          phase;      // 0: REQ without gnt, 1: WAIT, 2: HOLD with ready
        logic [31:0] target;
        logic [31:0] exp_addr;   // first request address after the redirect
        logic        exp_fault;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          req_cyc[$];
        logic [31:0] req_adr[$];
        int          acc_cyc[$];
        logic [31:0] acc_pc[$];
        logic [31:0] held;
        logic        found;
        logic        redir;
        logic [31:0] tgt;

        vecs[0] = '{1, 32'h0000_0100, 32'h0000_0100, 1'b0};
        vecs[1] = '{2, 32'h0000_0040, 32'h0000_0040, 1'b0};
        vecs[2] = '{0, 32'h0000_0200, 32'h0000_0200, 1'b0};
        vecs[3] = '{1, 32'h0000_0102, MIS ? 32'h0000_0004 : 32'h0000_0100, MIS};
        vecs[4] = '{2, 32'h0000_0041, MIS ? 32'h0000_0004 : 32'h0000_0040, MIS};
        vecs[5] = '{0, 32'h0000_0203, MIS ? 32'h0000_0000 : 32'h0000_0200, MIS};
        vecs[6] = '{1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};

        n_accept = 0;
        rst      = 1'b1;

        // ---- Reset then free-run: gnt immediate, rvalid +1, ready high ----
        do_reset();
        lat_cfg = 0;
        for (int c = 1; c <= 9; c++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (s_req) begin
                req_cyc.push_back(c);
                req_adr.push_back(s_addr);
            end
            if (s_valid) begin
                acc_cyc.push_back(c);
                acc_pc.push_back(s_pc);
            end
        end
        check("fr_req_count", req_cyc.size(), 3);
        check("fr_acc_count", acc_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < req_cyc.size()) begin
                check($sformatf("fr_req_cycle%0d", i), req_cyc[i], 1 + 3 * i);
                check($sformatf("fr_req_addr%0d", i), req_adr[i], 4 * i);
            end
            if (i < acc_cyc.size()) begin
                check($sformatf("fr_acc_cycle%0d", i), acc_cyc[i], 3 + 3 * i);
                check($sformatf("fr_acc_pc%0d", i), acc_pc[i], 4 * i);
            end
        end

        // ---- Decode stall: ready low for 5 cycles in HOLD ----
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            found = s_valid;
        end
        check("stall_reach_hold", {31'b0, found}, 32'h1);
        held = s_instr;
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            check("st_valid", {31'b0, s_valid}, 32'h1);
            check("st_instr", s_instr, held);
            check("st_pc_next", s_pc_next, s_pc_cur);
            check("st_no_req", {31'b0, s_req}, 32'h0);
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("st_release_pc_next", s_pc_next, 32'h10);

        // ---- Wrap: fetch at 0xFFFF_FFFC, accept, PC wraps to 0 ----
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
            if (s_valid) begin
                found = 1'b1;
                check("wrap_pc", s_pc, 32'hFFFF_FFFC);
                check("wrap_pc_next", s_pc_next, 32'h0);
            end
        end
        check("wrap_reached", {31'b0, found}, 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("wrap_next_req", s_addr, 32'h0);

        // ---- Reset in HOLD invalidates the buffer ----
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            found = s_valid;
        end
        check("midrst_reach_hold", {31'b0, found}, 32'h1);
        do_reset();

        // ---- Redirect vectors ----
        for (int v = 0; v < 7; v++) begin
            do_reset();
            case (vecs[v].phase)
                0: cycle(1'b1, vecs[v].target, 1'b0, 1'b0, 1'b0);
                1: begin
                    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
                    cycle(1'b1, vecs[v].target, 1'b0, 1'b0, 1'b0);
                end
                default: begin
                    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
                    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
                    cycle(1'b1, vecs[v].target, 1'b1, 1'b0, 1'b0);
                    check($sformatf("v%0d_in_hold", v), {31'b0, s_valid}, 32'h1);
                end
            endcase
            found = 1'b0;
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            check($sformatf("v%0d_fault", v), {31'b0, s_fault}, {31'b0, vecs[v].exp_fault});
            if (s_req) begin
                found = 1'b1;
                check($sformatf("v%0d_addr", v), s_addr, vecs[v].exp_addr);
            end
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            check($sformatf("v%0d_fault_end", v), {31'b0, s_fault}, 32'h0);
            if (!found && s_req) begin
                found = 1'b1;
                check($sformatf("v%0d_addr", v), s_addr, vecs[v].exp_addr);
            end
            for (int c = 0; c < 20 && !found; c++) begin
                cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
                if (s_req) begin
                    found = 1'b1;
                    check($sformatf("v%0d_addr", v), s_addr, vecs[v].exp_addr);
                end
            end
            if (!found) check($sformatf("v%0d_timeout", v), 32'h0, 32'h1);
        end

        // ---- Randomized traffic against the program-order scoreboard ----
        do_reset();
        n_accept = 0;
        for (int c = 0; c < 3000; c++) begin
            lat_cfg = $urandom_range(0, 2);
            redir   = ($urandom_range(0, 99) < 4);
            tgt     = 32'($urandom_range(0, 1023)) * 32'd4;
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8;
            if ($urandom_range(0, 3) == 0)  tgt = tgt | 32'($urandom_range(1, 3));
            cycle(redir, tgt, ($urandom_range(0, 9) < 6), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 7));
        end
        check("rand_progress", {31'b0, (n_accept > 100)}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
